// File: rtl/choose_ctrl_if.sv
// choose_ctrl_if
//   Bundles the choose-scene selection controller's inputs (round start and
//   decoded keyboard events) and its registered outputs (cursor, committed
//   picks, turn indicator, event pulses, done flag).
//   master : game/keyboard side; drives start/key_ready/key_code.
//   slave  : choose_ctrl side; drives the cursor and pick outputs.
interface choose_ctrl_if;
  logic       start;
  logic       key_ready;
  logic [8:0] key_code;
  logic [7:0] pokemon_id;
  logic [7:0] p1_id;
  logic [7:0] p2_id;
  logic       turn;
  logic       pick_pulse;
  logic       reject_pulse;
  logic       done;

  modport master (
    output start, key_ready, key_code,
    input  pokemon_id, p1_id, p2_id, turn, pick_pulse, reject_pulse, done
  );

  modport slave (
    input  start, key_ready, key_code,
    output pokemon_id, p1_id, p2_id, turn, pick_pulse, reject_pulse, done
  );
endinterface

// File: rtl/choose_ctrl.sv
// choose_ctrl
//   Moves a cursor over the 2x4 Pokemon grid from decoded key events and
//   sequences two players' picks (P1 then P2, no duplicate). Each accepted
//   key starts a HOLD_CYCLES lockout during which further keys are ignored.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - choose_ctrl_if.slave: start, key_ready, key_code in;
//            pokemon_id (1..8), p1_id, p2_id (0 = none), turn,
//            pick_pulse, reject_pulse, done out (all registered)
module choose_ctrl #(
  parameter int         HOLD_CYCLES = 2_500_000,
  parameter logic [8:0] KEY_UP      = 9'h01D,
  parameter logic [8:0] KEY_LEFT    = 9'h01C,
  parameter logic [8:0] KEY_DOWN    = 9'h01B,
  parameter logic [8:0] KEY_RIGHT   = 9'h023,
  parameter logic [8:0] KEY_ENTER   = 9'h05A,
  parameter logic [8:0] KEY_BACK    = 9'h066
) (
  input logic          clk,
  input logic          rst,
  choose_ctrl_if.slave bus
);

  // A zero-length lockout still needs a 1-bit counter that stays at 0.
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_P1   = 2'd1;
  localparam logic [1:0] ST_P2   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state_r;
  logic [2:0]    idx_r;      // cursor as 0..7
  logic [2:0]    p1_idx_r;   // P1 pick as 0..7, restores the cursor on undo
  logic [HW-1:0] hold_r;
  logic [7:0]    pid_r;
  logic [7:0]    p1_r;
  logic [7:0]    p2_r;
  logic          turn_r;
  logic          pick_r;
  logic          rej_r;
  logic          done_r;

  logic [1:0]    nxt_state_s;
  logic [2:0]    nxt_idx_s;
  logic [2:0]    nxt_p1_idx_s;
  logic [7:0]    nxt_p1_s;
  logic [7:0]    nxt_p2_s;
  logic          nxt_done_s;
  logic          nxt_pick_s;
  logic          nxt_rej_s;
  logic          accept_s;
  logic [7:0]    cur_id_s;
  logic [2:0]    col_inc_s;
  logic [2:0]    right_idx_s;
  logic [2:0]    left_idx_s;
  logic [2:0]    enter_idx_s;

  // Grid moves: column arithmetic wraps explicitly within a row of four.
  always_comb begin
    cur_id_s    = {5'd0, idx_r} + 8'd1;
    col_inc_s   = {1'b0, idx_r[1:0]} + 3'd1;
    right_idx_s = {idx_r[2], (col_inc_s == 3'd4) ? 2'd0 : col_inc_s[1:0]};
    left_idx_s  = {idx_r[2], (idx_r[1:0] == 2'd0) ? 2'd3 : (idx_r[1:0] - 2'd1)};
    enter_idx_s = (idx_r == 3'd7) ? 3'd0 : (idx_r + 3'd1);
  end

  // Next-state decode: start beats any key; keys only while unlocked.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_idx_s    = idx_r;
    nxt_p1_idx_s = p1_idx_r;
    nxt_p1_s     = p1_r;
    nxt_p2_s     = p2_r;
    nxt_done_s   = done_r;
    nxt_pick_s   = 1'b0;
    nxt_rej_s    = 1'b0;
    accept_s     = 1'b0;
    if (bus.start) begin
      nxt_state_s = ST_P1;
      nxt_idx_s   = 3'd0;
      nxt_p1_s    = 8'd0;
      nxt_p2_s    = 8'd0;
      nxt_done_s  = 1'b0;
    end else if (bus.key_ready && (hold_r == '0)) begin
      case (state_r)
        ST_P1, ST_P2: begin
          if (bus.key_code == KEY_RIGHT) begin
            nxt_idx_s = right_idx_s;
            accept_s  = 1'b1;
          end else if (bus.key_code == KEY_LEFT) begin
            nxt_idx_s = left_idx_s;
            accept_s  = 1'b1;
          end else if ((bus.key_code == KEY_UP) || (bus.key_code == KEY_DOWN)) begin
            // Two rows only: up and down both flip the row bit (id +/- 4).
            nxt_idx_s = idx_r ^ 3'b100;
            accept_s  = 1'b1;
          end else if (bus.key_code == KEY_ENTER) begin
            accept_s = 1'b1;
            if (state_r == ST_P1) begin
              nxt_p1_s     = cur_id_s;
              nxt_p1_idx_s = idx_r;
              nxt_idx_s    = enter_idx_s;
              nxt_pick_s   = 1'b1;
              nxt_state_s  = ST_P2;
            end else if (cur_id_s != p1_r) begin
              nxt_p2_s    = cur_id_s;
              nxt_done_s  = 1'b1;
              nxt_pick_s  = 1'b1;
              nxt_state_s = ST_DONE;
            end else begin
              nxt_rej_s = 1'b1;
            end
          end else if ((bus.key_code == KEY_BACK) && (state_r == ST_P2)) begin
            accept_s    = 1'b1;
            nxt_idx_s   = p1_idx_r;
            nxt_p1_s    = 8'd0;
            nxt_state_s = ST_P1;
          end else begin
            accept_s = 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.key_code == KEY_BACK) begin
            accept_s    = 1'b1;
            nxt_p2_s    = 8'd0;
            nxt_done_s  = 1'b0;
            nxt_state_s = ST_P2;
          end else begin
            accept_s = 1'b0;
          end
        end
        default: accept_s = 1'b0;
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // State, cursor, picks, lockout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= 3'd0;
      p1_idx_r <= 3'd0;
      hold_r   <= '0;
      pid_r    <= 8'd1;
      p1_r     <= 8'd0;
      p2_r     <= 8'd0;
      turn_r   <= 1'b0;
      pick_r   <= 1'b0;
      rej_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= nxt_state_s;
      idx_r    <= nxt_idx_s;
      p1_idx_r <= nxt_p1_idx_s;
      pid_r    <= {5'd0, nxt_idx_s} + 8'd1;
      p1_r     <= nxt_p1_s;
      p2_r     <= nxt_p2_s;
      turn_r   <= (nxt_state_s == ST_P2) || (nxt_state_s == ST_DONE);
      pick_r   <= nxt_pick_s;
      rej_r    <= nxt_rej_s;
      done_r   <= nxt_done_s;
      if (bus.start) begin
        hold_r <= '0;
      end else if (accept_s) begin
        hold_r <= HOLD_LOAD;
      end else if (hold_r != '0) begin
        hold_r <= hold_r - 1'b1;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  assign bus.pokemon_id   = pid_r;
  assign bus.p1_id        = p1_r;
  assign bus.p2_id        = p2_r;
  assign bus.turn         = turn_r;
  assign bus.pick_pulse   = pick_r;
  assign bus.reject_pulse = rej_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_choose_ctrl.sv
// tb_choose_ctrl
//   Drives choose_ctrl (HOLD_CYCLES = 4) with directed scenarios followed by
//   random key/start/reset traffic. A behavioural model predicts the outputs
//   after every clock edge and queues them; a monitor pops and compares.
module tb_choose_ctrl;
  localparam int H = 4;
  localparam logic [8:0] K_UP    = 9'h01D;
  localparam logic [8:0] K_LEFT  = 9'h01C;
  localparam logic [8:0] K_DOWN  = 9'h01B;
  localparam logic [8:0] K_RIGHT = 9'h023;
  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_BACK  = 9'h066;

  localparam int M_IDLE = 0;
  localparam int M_P1   = 1;
  localparam int M_P2   = 2;
  localparam int M_DONE = 3;

  typedef struct packed {
    logic [7:0] pid;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       turn;
    logic       pick;
    logic       rej;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  choose_ctrl_if bus();

  choose_ctrl #(.HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: ids 1..8, lockout tracked as the edge of the last accept.
  int m_state = M_IDLE;
  int m_cur   = 1;
  int m_p1    = 0;
  int m_p2    = 0;
  int m_last  = -100;
  int m_cyc   = 0;

  function automatic void model_step(input logic r, input logic s, input logic kr,
                                     input logic [8:0] kc);
    exp_t e;
    bit   acc;
    bit   pick;
    bit   rej;
    int   row;
    int   col;
    acc  = 1'b0;
    pick = 1'b0;
    rej  = 1'b0;
    if (r) begin
      m_state = M_IDLE; m_cur = 1; m_p1 = 0; m_p2 = 0; m_last = -100;
    end else if (s) begin
      m_state = M_P1; m_cur = 1; m_p1 = 0; m_p2 = 0; m_last = -100;
    end else if (kr && (m_cyc >= m_last + H + 1)) begin
      row = (m_cur - 1) / 4;
      col = (m_cur - 1) % 4;
      if (m_state == M_P1 || m_state == M_P2) begin
        if (kc == K_RIGHT) begin
          m_cur = row * 4 + (col + 1) % 4 + 1; acc = 1'b1;
        end else if (kc == K_LEFT) begin
          m_cur = row * 4 + (col + 3) % 4 + 1; acc = 1'b1;
        end else if (kc == K_UP || kc == K_DOWN) begin
          m_cur = (m_cur > 4) ? m_cur - 4 : m_cur + 4; acc = 1'b1;
        end else if (kc == K_ENTER) begin
          acc = 1'b1;
          if (m_state == M_P1) begin
            m_p1 = m_cur; m_cur = m_cur % 8 + 1; m_state = M_P2; pick = 1'b1;
          end else if (m_cur != m_p1) begin
            m_p2 = m_cur; m_state = M_DONE; pick = 1'b1;
          end else begin
            rej = 1'b1;
          end
        end else if (kc == K_BACK && m_state == M_P2) begin
          m_cur = m_p1; m_p1 = 0; m_state = M_P1; acc = 1'b1;
        end
      end else if (m_state == M_DONE && kc == K_BACK) begin
        m_p2 = 0; m_state = M_P2; acc = 1'b1;
      end
      if (acc) m_last = m_cyc;
    end
    e.pid  = 8'(m_cur);
    e.p1   = 8'(m_p1);
    e.p2   = 8'(m_p2);
    e.turn = (m_state == M_P2 || m_state == M_DONE);
    e.pick = pick;
    e.rej  = rej;
    e.done = (m_state == M_DONE);
    exp_q.push_back(e);
    m_cyc++;
  endfunction

  task automatic apply(input logic r, input logic s, input logic kr, input logic [8:0] kc);
    @(negedge clk);
    rst           = r;
    bus.start     = s;
    bus.key_ready = kr;
    bus.key_code  = kc;
    model_step(r, s, kr, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 9'h000);
  endtask

  task automatic key(input logic [8:0] kc, input int gap);
    apply(1'b0, 1'b0, 1'b1, kc);
    idle(gap);
  endtask

  task automatic start_round();
    apply(1'b0, 1'b1, 1'b0, 9'h000);
  endtask

  // Monitor: one predicted output set per clock edge, compared just after it.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.pid  = bus.pokemon_id;
        a.p1   = bus.p1_id;
        a.p2   = bus.p2_id;
        a.turn = bus.turn;
        a.pick = bus.pick_pulse;
        a.rej  = bus.reject_pulse;
        a.done = bus.done;
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs vec=%0d t=%0t: got pid=%0d p1=%0d p2=%0d turn=%b pick=%b rej=%b done=%b, required pid=%0d p1=%0d p2=%0d turn=%b pick=%b rej=%b done=%b",
                   n_vec, $time, a.pid, a.p1, a.p2, a.turn, a.pick, a.rej, a.done,
                   e.pid, e.p1, e.p2, e.turn, e.pick, e.rej, e.done);
        end
      end
    end
  end

  initial begin
    logic [8:0] ktab [7];
    int         sel;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.key_ready = 1'b0;
    bus.key_code  = 9'h000;
    ktab[0] = K_UP; ktab[1] = K_LEFT; ktab[2] = K_DOWN; ktab[3] = K_RIGHT;
    ktab[4] = K_ENTER; ktab[5] = K_BACK; ktab[6] = 9'h000;

    // Reset, then keys before any start must do nothing.
    apply(1'b1, 1'b0, 1'b0, 9'h000);
    apply(1'b1, 1'b0, 1'b0, 9'h000);
    idle(2);
    key(K_RIGHT, 5);
    key(K_ENTER, 5);
    key(K_BACK, 5);

    // Row wrap on RIGHT, then row toggle and LEFT wrap.
    start_round();
    for (int i = 0; i < 4; i++) key(K_RIGHT, 5);
    key(K_DOWN, 5);
    key(K_LEFT, 5);

    // Lockout: keys at t, t+3 (ignored), t+5 (accepted).
    key(K_RIGHT, 2);
    key(K_RIGHT, 1);
    key(K_RIGHT, 5);

    // Unknown code does not load the lockout; the next cycle's key is taken.
    key(9'h1FF, 0);
    key(K_RIGHT, 5);

    // Normal pick from cursor 3, then P2 pick.
    start_round();
    key(K_RIGHT, 5);
    key(K_RIGHT, 5);
    key(K_ENTER, 5);
    key(K_ENTER, 5);

    // P1 takes 8, P2 steers back to 8 and is refused, then undoes.
    start_round();
    key(K_LEFT, 5);
    key(K_DOWN, 5);
    key(K_ENTER, 5);
    key(K_BACK, 0);
    key(K_LEFT, 5);
    key(K_DOWN, 5);
    key(K_ENTER, 5);
    key(K_BACK, 5);
    key(K_UP, 5);

    // Reach DONE, then start and BACK together; start must win.
    key(K_ENTER, 5);
    key(K_ENTER, 5);
    key(K_BACK, 5);
    key(K_RIGHT, 5);
    key(K_ENTER, 5);
    apply(1'b0, 1'b1, 1'b1, K_BACK);
    idle(2);

    // Reset in the middle of P2 selection, with a key present.
    key(K_ENTER, 5);
    apply(1'b1, 1'b0, 1'b1, K_RIGHT);
    idle(3);

    // Random traffic.
    start_round();
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 6);
      if (sel == 6) ktab[6] = 9'($urandom);
      apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) == 0), ktab[sel]);
    end
    idle(2);

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
